car_sensor_decoder: RTL and testbench
=====================================

CAR_SENSOR_DECODER -- requirements
Module: car_sensor_decoder

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, consecutive stable cycles required before a sensor change is accepted; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, release is sampled on clk.
REQ-004 outer_raw  input  1  outer photo-sensor from the GPIO switch; 1 = beam blocked; asynchronous to clk.
REQ-005 inner_raw  input  1  inner photo-sensor from the GPIO switch; 1 = beam blocked; asynchronous to clk.
REQ-006 outer_clean  output  1  synchronized, debounced outer sensor level.
REQ-007 inner_clean  output  1  synchronized, debounced inner sensor level.
REQ-008 enter  output  1  one-cycle pulse; one car completed entry; feeds parking_lot_occupancy increment.
REQ-009 exit  output  1  one-cycle pulse; one car completed exit; feeds parking_lot_occupancy decrement.
REQ-010 seq_error  output  1  one-cycle pulse; illegal sensor sequence detected.

Function
REQ-011 Each raw input SHALL pass through two series flops (sync stage); the second flop output is the synced level s.
REQ-012 Per sensor, an 8-bit counter SHALL increment each cycle s != clean and clear to 0 whenever s == clean.
REQ-013 When s != clean and counter == DEBOUNCE_CYCLES-1, clean SHALL take s on that edge and the counter SHALL clear; a glitch shorter than DEBOUNCE_CYCLES synced cycles never changes clean.
REQ-014 Latency SHALL be: a raw change held stable appears on *_clean exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-015 Direction FSM SHALL evaluate pattern P = {outer_clean, inner_clean} each cycle; states IDLE, E1, E2, E3, X1, X2, X3, ERR.
REQ-016 IDLE: P=10 -> E1; P=01 -> X1; P=00 stay; P=11 -> ERR with seq_error.
REQ-017 Entry path: E1 (P=10 stay, 11 -> E2, 00 -> IDLE, 01 -> ERR); E2 (11 stay, 01 -> E3, 10 -> E1, 00 -> ERR); E3 (01 stay, 00 -> IDLE with enter, 11 -> E2, 10 -> ERR).
REQ-018 Exit path SHALL mirror entry with outer/inner swapped: X1 on 01, X2 on 11, X3 on 10; X3 with P=00 -> IDLE with exit.
REQ-019 Backward steps (reversal) SHALL NOT pulse any output; E1->IDLE and X1->IDLE on P=00 are silent aborts.
REQ-020 ERR SHALL hold until P=00, then go to IDLE; seq_error pulses only on the transition into ERR, never while holding.
REQ-021 enter, exit, seq_error SHALL be registered, asserted for exactly one cycle on the edge after the clean pattern that triggers them; at most one of the three is high in any cycle.
REQ-022 Total latency: final raw release to enter/exit pulse SHALL be 3+DEBOUNCE_CYCLES edges (7 at default).
REQ-023 Simultaneous change of both sensors in one clean update SHALL be evaluated as a single pattern jump (e.g. 10->01 from E1 is ERR).

Reset
REQ-024 While reset=0: sync flops, outer_clean, inner_clean, counters = 0; FSM = IDLE; enter, exit, seq_error = 0.
REQ-025 Reset asserted mid-sequence SHALL abandon the sequence with no pulse; after release the FSM starts from IDLE using fresh clean values.
REQ-026 If a sensor is blocked at reset release, clean SHALL rise only after the normal 2+DEBOUNCE_CYCLES latency, then be treated by the FSM like any other change.

Verification
REQ-027 D=4; raw {outer,inner} = 10,11,01,00, each held 10 cycles -> exactly one enter pulse, 7 edges after last change; exit=seq_error=0.
REQ-028 D=4; raw = 01,11,10,00, each held 10 cycles -> exactly one exit pulse; enter=0.
REQ-029 D=4; outer_raw high for 3 cycles then low -> outer_clean stays 0, no pulses; high for 4 synced cycles -> outer_clean rises.
REQ-030 Reversal raw = 10,11,10,00 -> no pulses, FSM back at IDLE; then full entry sequence -> one enter.
REQ-031 From IDLE raw = 11 held -> one seq_error pulse, FSM in ERR; 11 held further -> no more pulses; 00 -> IDLE, no pulse.
REQ-032 Reset=0 asserted while FSM in E2 -> all outputs 0 immediately; release, complete sequence 10,11,01,00 -> exactly one enter.

Source files
------------

// File: rtl/car_sensor_decoder.sv
// Two-sensor car direction decoder: synchronizes and debounces the outer/inner photo-sensors,
// then walks a direction FSM that pulses enter, exit or seq_error for each completed pattern.
module car_sensor_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic outer_raw,
    input  logic inner_raw,
    output logic outer_clean,
    output logic inner_clean,
    output logic enter,
    output logic exit,
    output logic seq_error
);

    localparam logic [7:0] LastCnt = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StE1, StE2, StE3, StX1, StX2, StX3, StErr
    } state_e;

    // Bit 1 is the outer sensor, bit 0 the inner sensor throughout.
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      clean;
    logic [1:0][7:0] cnt;

    state_e state_q, state_d;
    logic   enter_d, exit_d, seq_error_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            clean <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= {outer_raw, inner_raw};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != clean[i]) begin
                    if (cnt[i] == LastCnt) begin
                        clean[i] <= sync2[i];
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 8'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign outer_clean = clean[1];
    assign inner_clean = clean[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            enter     <= 1'b0;
            exit      <= 1'b0;
            seq_error <= 1'b0;
        end else begin
            state_q   <= state_d;
            enter     <= enter_d;
            exit      <= exit_d;
            seq_error <= seq_error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: unique case (clean)
                2'b10: state_d = StE1;
                2'b01: state_d = StX1;
                2'b11: state_d = StErr;
                default: state_d = StIdle;
            endcase
            StE1: unique case (clean)
                2'b11: state_d = StE2;
                2'b00: state_d = StIdle;
                2'b01: state_d = StErr;
                default: state_d = StE1;
            endcase
            StE2: unique case (clean)
                2'b01: state_d = StE3;
                2'b10: state_d = StE1;
                2'b00: state_d = StErr;
                default: state_d = StE2;
            endcase
            StE3: unique case (clean)
                2'b00: state_d = StIdle;
                2'b11: state_d = StE2;
                2'b10: state_d = StErr;
                default: state_d = StE3;
            endcase
            StX1: unique case (clean)
                2'b11: state_d = StX2;
                2'b00: state_d = StIdle;
                2'b10: state_d = StErr;
                default: state_d = StX1;
            endcase
            StX2: unique case (clean)
                2'b10: state_d = StX3;
                2'b01: state_d = StX1;
                2'b00: state_d = StErr;
                default: state_d = StX2;
            endcase
            StX3: unique case (clean)
                2'b00: state_d = StIdle;
                2'b11: state_d = StX2;
                2'b01: state_d = StErr;
                default: state_d = StX3;
            endcase
            default: state_d = (clean == 2'b00) ? StIdle : StErr;
        endcase
    end

    // Pulses fire only on completion or on entry into ERR; aborts and reversals stay silent.
    always_comb begin
        enter_d     = (state_q == StE3) && (clean == 2'b00);
        exit_d      = (state_q == StX3) && (clean == 2'b00);
        seq_error_d = (state_q != StErr) && (state_d == StErr);
    end

endmodule

// File: tb/tb_car_sensor_decoder.sv
// Directed bench for car_sensor_decoder: expected pulses are queued with their due cycle when
// stimulus is driven, and a negedge monitor pops and checks them as the DUT pulses.
module tb_car_sensor_decoder;

    localparam int D = 4;
    localparam int KEnter = 1;
    localparam int KExit  = 2;
    localparam int KErr   = 3;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic outer_raw = 1'b0;
    logic inner_raw = 1'b0;
    logic outer_clean, inner_clean, enter, exit, seq_error;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    car_sensor_decoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .outer_raw   (outer_raw),
        .inner_raw   (inner_raw),
        .outer_clean (outer_clean),
        .inner_clean (inner_clean),
        .enter       (enter),
        .exit        (exit),
        .seq_error   (seq_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Apply pattern at a negedge; the next rising edge is the first to sample it.
    task automatic drive(input logic [1:0] p, input int hold);
        {outer_raw, inner_raw} = p;
        repeat (hold) @(negedge clk);
    endtask

    task automatic expect_pulse(input int kind);
        exp_t e;
        e.kind = kind;
        e.cyc  = cyc + 3 + D;
        sb.push_back(e);
    endtask

    task automatic entry_seq();
        drive(2'b10, 10);
        drive(2'b11, 10);
        drive(2'b01, 10);
        expect_pulse(KEnter);
        drive(2'b00, 12);
    endtask

    always @(negedge clk) begin
        int   kind;
        exp_t e;
        check("onehot", int'(enter) + int'(exit) + int'(seq_error) <= 1, 1);
        if (enter || exit || seq_error) begin
            kind = enter ? KEnter : (exit ? KExit : KErr);
            if (sb.size() == 0) begin
                check("unexpected_pulse", kind, 0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", kind, e.kind);
                check("pulse_cycle", cyc, e.cyc);
            end
        end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            check("missed_pulse", 0, e.kind);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outer_clean", outer_clean, 0);
        check("rst_inner_clean", inner_clean, 0);
        check("rst_enter", enter, 0);
        check("rst_exit", exit, 0);
        check("rst_seq_error", seq_error, 0);
        reset = 1'b1;
        drive(2'b00, 5);

        // Clean entry and exit
        entry_seq();
        drive(2'b01, 10);
        drive(2'b11, 10);
        drive(2'b10, 10);
        expect_pulse(KExit);
        drive(2'b00, 12);

        // Three-cycle glitch is rejected
        drive(2'b10, 3);
        {outer_raw, inner_raw} = 2'b00;
        for (int i = 0; i < 10; i++) begin
            check("glitch_outer_clean", outer_clean, 0);
            @(negedge clk);
        end
        // Four-cycle pulse is accepted exactly at 2+D edges; then a silent E1 abort
        drive(2'b10, 4);
        {outer_raw, inner_raw} = 2'b00;
        @(negedge clk);
        check("deb_outer_early", outer_clean, 0);
        @(negedge clk);
        check("deb_outer_rise", outer_clean, 1);
        drive(2'b00, 12);
        check("deb_outer_fall", outer_clean, 0);

        // Reversal then a full entry
        drive(2'b10, 10);
        drive(2'b11, 10);
        drive(2'b10, 10);
        drive(2'b00, 12);
        entry_seq();

        // Both sensors from IDLE: single seq_error, held, then release silently
        expect_pulse(KErr);
        drive(2'b11, 30);
        drive(2'b10, 10);
        drive(2'b00, 12);
        entry_seq();

        // Simultaneous jump 10 -> 01 from E1
        drive(2'b10, 10);
        expect_pulse(KErr);
        drive(2'b01, 12);
        drive(2'b00, 12);

        // Reset in E2, with outer still blocked at release
        drive(2'b10, 10);
        drive(2'b11, 10);
        check("e2_outer_clean", outer_clean, 1);
        check("e2_inner_clean", inner_clean, 1);
        {outer_raw, inner_raw} = 2'b10;
        reset = 1'b0;
        #1;
        check("async_outer_clean", outer_clean, 0);
        check("async_inner_clean", inner_clean, 0);
        check("async_pulses", int'(enter) + int'(exit) + int'(seq_error), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (1 + D) @(negedge clk);
        check("rel_outer_early", outer_clean, 0);
        @(negedge clk);
        check("rel_outer_rise", outer_clean, 1);
        drive(2'b10, 4);
        drive(2'b11, 10);
        drive(2'b01, 10);
        expect_pulse(KEnter);
        drive(2'b00, 12);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
